dijkstra_path_extractor: RTL and testbench

Downstream consumer of the Dijkstra engine's result. Once the engine has written its predecessor ("prev") vector to memory, this block walks it backwards from `destination` to `source` through the shared memory read port. It buffers the hops in an internal LIFO stack and then streams the shortest path out source-first over a valid/ready interface. It also reports the path length, and flags unreachable, malformed or over-long paths.

---
 rtl/dijkstra_path_extractor_if.sv | 43 ++++
 rtl/dijkstra_path_extractor.sv | 182 ++++++++++++++++++
 tb/tb_dijkstra_path_extractor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_path_extractor_if.sv
// Bundles the signals between the path extractor and its environment.
// The bundle holds the extraction request, the memory read port and the
// path output stream.
//   master : the extractor side. It receives the request, issues the memory
//            reads and drives the path stream and the status.
//   slave  : the environment side. It issues the request, answers the reads
//            and consumes the path.
interface dijkstra_path_extractor_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32
);
    logic                   start;
    logic [INDEX_WIDTH-1:0] source;
    logic [INDEX_WIDTH-1:0] destination;
    logic [INDEX_WIDTH-1:0] number_of_nodes;
    logic [MADDR_WIDTH-1:0] prev_base;
    logic                   mem_read_enable;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic [MDATA_WIDTH-1:0] mem_read_data;
    logic                   mem_read_ready;
    logic                   path_valid;
    logic [INDEX_WIDTH-1:0] path_node;
    logic                   path_last;
    logic                   path_ready;
    logic [INDEX_WIDTH-1:0] path_length;
    logic                   done;
    logic                   error;

    modport master (
        input  start, source, destination, number_of_nodes, prev_base,
               mem_read_data, mem_read_ready, path_ready,
        output mem_read_enable, mem_addr, path_valid, path_node, path_last,
               path_length, done, error
    );

    modport slave (
        output start, source, destination, number_of_nodes, prev_base,
               mem_read_data, mem_read_ready, path_ready,
        input  mem_read_enable, mem_addr, path_valid, path_node, path_last,
               path_length, done, error
    );
endinterface

// File: rtl/dijkstra_path_extractor.sv
// Walks the Dijkstra predecessor vector in memory backwards, from destination
// to source. The hops are pushed onto a LIFO stack and are then streamed out
// source-first.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (master) : start/source/destination/number_of_nodes/prev_base request,
//                  mem_read_enable/mem_addr/mem_read_data/mem_read_ready read
//                  port, path_valid/path_node/path_last/path_ready stream,
//                  path_length/done/error status
module dijkstra_path_extractor #(
    parameter int MAX_NODES   = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    dijkstra_path_extractor_if.master bus
);
    localparam int SP_W  = $clog2(MAX_NODES + 1);
    localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [MADDR_WIDTH-1:0] BYTES = MADDR_WIDTH'(MDATA_WIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_FETCH, S_EMIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [SP_W-1:0]        sp_q, sp_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [INDEX_WIDTH-1:0] src_q, n_q;
    logic [MADDR_WIDTH-1:0] base_q;
    logic [INDEX_WIDTH-1:0] stack_q [MAX_NODES];
    logic                   mem_re_q, mem_re_d;
    logic [MADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                   pvalid_q, pvalid_d;
    logic [INDEX_WIDTH-1:0] pnode_q, pnode_d;
    logic                   plast_q, plast_d;
    logic [INDEX_WIDTH-1:0] plen_q, plen_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   lat_en, push_en;
    logic [INDEX_WIDTH-1:0] p;
    logic [IDX_W-1:0]       next_idx;
    logic                   unused_rdata;

    assign p            = bus.mem_read_data[INDEX_WIDTH-1:0];
    assign unused_rdata = ^bus.mem_read_data;
    // The node that follows the one on the output sits two below sp: sp still
    // counts the node being handed over in this cycle.
    assign next_idx     = sp_q[IDX_W-1:0] - IDX_W'(2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sp_q       <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            pvalid_q   <= 1'b0;
            pnode_q    <= '0;
            plast_q    <= 1'b0;
            plen_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            pvalid_q   <= pvalid_d;
            pnode_q    <= pnode_d;
            plast_q    <= plast_d;
            plen_q     <= plen_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clock) begin
        cur_q <= cur_d;
        if (lat_en) begin
            src_q  <= bus.source;
            n_q    <= bus.number_of_nodes;
            base_q <= bus.prev_base;
        end
        if (push_en) stack_q[sp_q[IDX_W-1:0]] <= cur_q;
    end

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        cur_d      = cur_q;
        mem_re_d   = mem_re_q;
        mem_addr_d = mem_addr_q;
        pvalid_d   = pvalid_q;
        pnode_d    = pnode_q;
        plast_d    = plast_q;
        plen_d     = plen_q;
        done_d     = done_q;
        error_d    = error_q;
        lat_en     = 1'b0;
        push_en    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    lat_en  = 1'b1;
                    cur_d   = bus.destination;
                    sp_d    = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    plen_d  = '0;
                    if (bus.source >= bus.number_of_nodes ||
                        bus.destination >= bus.number_of_nodes) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                if (cur_q == src_q) begin
                    // The node just pushed is the source, so it becomes the
                    // first node on the output.
                    state_d  = S_EMIT;
                    plen_d   = INDEX_WIDTH'(sp_q) + INDEX_WIDTH'(1);
                    pvalid_d = 1'b1;
                    pnode_d  = cur_q;
                    plast_d  = (sp_q == '0);
                end else if (sp_q + SP_W'(1) == SP_W'(MAX_NODES)) begin
                    // The stack is full and the source has not been reached.
                    // This covers both cycles and over-long paths.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    state_d    = S_FETCH;
                    mem_re_d   = 1'b1;
                    mem_addr_d = base_q + MADDR_WIDTH'(cur_q) * BYTES;
                end
            end
            S_FETCH: begin
                if (bus.mem_read_ready) begin
                    mem_re_d = 1'b0;
                    if (p == {INDEX_WIDTH{1'b1}} || p >= n_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        cur_d   = p;
                        state_d = S_PUSH;
                    end
                end
            end
            S_EMIT: begin
                if (bus.path_ready) begin
                    sp_d = sp_q - SP_W'(1);
                    if (plast_q) begin
                        state_d  = S_DONE;
                        pvalid_d = 1'b0;
                        plast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        pnode_d = stack_q[next_idx];
                        plast_d = (sp_q == SP_W'(2));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_read_enable = mem_re_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.path_valid      = pvalid_q;
    assign bus.path_node       = pnode_q;
    assign bus.path_last       = plast_q;
    assign bus.path_length     = plen_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
endmodule

// File: tb/tb_dijkstra_path_extractor.sv
module tb_dijkstra_path_extractor;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dijkstra_path_extractor_if #(.INDEX_WIDTH(8), .MADDR_WIDTH(32), .MDATA_WIDTH(32)) bif ();
    dijkstra_path_extractor #(.MAX_NODES(4), .INDEX_WIDTH(8), .MADDR_WIDTH(32), .MDATA_WIDTH(32))
        dut (.clock(clock), .reset(reset), .bus(bif));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] memw [16];
    logic [31:0] cur_base = 32'h0;
    int          wait_cycles = 0;
    bit          bp_mode = 1'b0;
    logic [31:0] reads [$];
    logic [7:0]  nodes [$];
    logic        lasts [$];
    int          first_valid = -1;
    int          re_cycles = 0;
    int          start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_path(input string tag, input int cnt, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, nodes.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("%s_node%0d", tag, i), (i < nodes.size()) ? 32'(nodes[i]) : 32'hDEAD, 32'(e[i]));
            chk($sformatf("%s_last%0d", tag, i), (i < lasts.size()) ? 32'(lasts[i]) : 32'hDEAD, (i == cnt - 1) ? 1 : 0);
        end
    endtask

    task automatic chk_reads(input string tag, input int cnt, input logic [31:0] a0, a1, a2);
        logic [31:0] a [3];
        a = '{a0, a1, a2};
        chk({tag, "_reads"}, reads.size(), cnt);
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s_addr%0d", tag, i), (i < reads.size()) ? reads[i] : 32'hDEAD, a[i]);
    endtask

    // Memory responder: answers after wait_cycles extra cycles and checks that
    // the request is held steady while it waits.
    initial begin : mem_model
        int wcnt;
        int idx;
        logic [31:0] held;
        wcnt = 0;
        held = '0;
        bif.mem_read_ready = 1'b0;
        bif.mem_read_data  = '0;
        forever begin
            @(negedge clock);
            if (bif.mem_read_enable === 1'b1) re_cycles++;
            if (bif.mem_read_enable === 1'b1 && bif.mem_read_ready === 1'b0) begin
                if (wcnt == 0) held = bif.mem_addr;
                else chk("addr_hold", bif.mem_addr, held);
                if (wcnt == wait_cycles) begin
                    idx = int'(((bif.mem_addr - cur_base) >> 2) & 32'hF);
                    bif.mem_read_ready = 1'b1;
                    bif.mem_read_data  = memw[idx];
                    reads.push_back(bif.mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                bif.mem_read_ready = 1'b0;
                bif.mem_read_data  = '0;
                wcnt = 0;
            end
        end
    end

    // Path consumer: drives path_ready, records handshakes and checks that
    // stalled output is held.
    initial begin : path_mon
        bit pat [4];
        int k;
        bit stall;
        logic [7:0] snode;
        logic slast;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        stall = 1'b0;
        snode = '0;
        slast = 1'b0;
        bif.path_ready = 1'b0;
        forever begin
            @(negedge clock);
            bif.path_ready = bp_mode ? pat[k % 4] : 1'b1;
            k++;
            if (stall) begin
                chk("hold_valid", bif.path_valid, 1);
                chk("hold_node", bif.path_node, snode);
                chk("hold_last", bif.path_last, slast);
            end
            if (bif.path_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (bif.path_valid === 1'b1 && bif.path_ready === 1'b1) begin
                nodes.push_back(bif.path_node);
                lasts.push_back(bif.path_last);
            end
            stall = (bif.path_valid === 1'b1) && (bif.path_ready === 1'b0);
            snode = bif.path_node;
            slast = bif.path_last;
        end
    end

    task automatic prep(input logic [7:0] s, d, n, input logic [31:0] base, input int w, input bit bp);
        @(negedge clock);
        wait_cycles = w;
        bp_mode     = bp;
        cur_base    = base;
        reads.delete();
        nodes.delete();
        lasts.delete();
        first_valid = -1;
        re_cycles   = 0;
        bif.source          = s;
        bif.destination     = d;
        bif.number_of_nodes = n;
        bif.prev_base       = base;
        bif.start           = 1'b1;
        @(negedge clock);
        bif.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run(input logic [7:0] s, d, n, input logic [31:0] base, input int w, input bit bp);
        prep(s, d, n, base, w, bp);
        for (int i = 0; i < 400 && bif.done !== 1'b1; i++) @(negedge clock);
        chk("done_seen", bif.done, 1);
    endtask

    initial begin : stim
        reset = 1'b1;
        bif.start = 1'b0;
        bif.source = '0;
        bif.destination = '0;
        bif.number_of_nodes = '0;
        bif.prev_base = '0;
        for (int i = 0; i < 16; i++) memw[i] = 32'h0000_00FF;
        memw[0] = 32'hFF; memw[1] = 32'h0; memw[2] = 32'h1; memw[3] = 32'h1; memw[4] = 32'h2;
        repeat (3) @(negedge clock);
        chk("rst_mem_re", bif.mem_read_enable, 0);
        chk("rst_mem_addr", bif.mem_addr, 0);
        chk("rst_pvalid", bif.path_valid, 0);
        chk("rst_pnode", bif.path_node, 0);
        chk("rst_plast", bif.path_last, 0);
        chk("rst_plen", bif.path_length, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_error", bif.error, 0);
        reset = 1'b0;

        // Nominal path 0 -> 1 -> 2 -> 4, zero wait, always ready.
        run(8'd0, 8'd4, 8'd5, 32'h1000, 0, 1'b0);
        chk_reads("nom", 3, 32'h1010, 32'h1008, 32'h1004);
        chk_path("nom", 4, 8'd0, 8'd1, 8'd2, 8'd4);
        chk("nom_len", bif.path_length, 4);
        chk("nom_err", bif.error, 0);
        chk("nom_latency", first_valid - start_cyc, 7);
        chk("nom_re_cycles", re_cycles, 3);

        // Unreachable destination.
        memw[3] = 32'hFF;
        run(8'd0, 8'd3, 8'd5, 32'h1000, 0, 1'b0);
        chk_reads("unr", 1, 32'h100C, 32'h0, 32'h0);
        chk("unr_err", bif.error, 1);
        chk("unr_nodes", nodes.size(), 0);
        chk("unr_len", bif.path_length, 0);

        // Predecessor value out of range.
        memw[3] = 32'h7;
        run(8'd0, 8'd3, 8'd5, 32'h1000, 0, 1'b0);
        chk("oor_err", bif.error, 1);
        chk("oor_reads", reads.size(), 1);
        chk("oor_nodes", nodes.size(), 0);
        memw[3] = 32'h1;

        // Source equals destination: single node, no memory traffic.
        run(8'd2, 8'd2, 8'd5, 32'h1000, 0, 1'b0);
        chk("triv_re_cycles", re_cycles, 0);
        chk_path("triv", 1, 8'd2, 8'd0, 8'd0, 8'd0);
        chk("triv_len", bif.path_length, 1);
        chk("triv_err", bif.error, 0);
        chk("triv_latency", first_valid - start_cyc, 1);

        // Destination index out of range: immediate error.
        run(8'd0, 8'd5, 8'd5, 32'h1000, 0, 1'b0);
        chk("rng_err", bif.error, 1);
        chk("rng_re_cycles", re_cycles, 0);
        chk("rng_nodes", nodes.size(), 0);
        chk("rng_len", bif.path_length, 0);

        // Predecessor loop 2 <-> 1 fills the four-entry stack.
        memw[1] = 32'h2;
        run(8'd0, 8'd2, 8'd5, 32'h1000, 0, 1'b0);
        chk("loop_err", bif.error, 1);
        chk("loop_nodes", nodes.size(), 0);
        chk("loop_len", bif.path_length, 0);
        memw[1] = 32'h0;

        // Nominal path with three wait cycles per read and a stalling consumer.
        run(8'd0, 8'd4, 8'd5, 32'h1000, 3, 1'b1);
        chk_reads("bp", 3, 32'h1010, 32'h1008, 32'h1004);
        chk_path("bp", 4, 8'd0, 8'd1, 8'd2, 8'd4);
        chk("bp_len", bif.path_length, 4);
        chk("bp_err", bif.error, 0);
        chk("bp_latency", first_valid - start_cyc, 16);

        // Address arithmetic wraps: base + 2*4 lands on 0.
        run(8'd1, 8'd2, 8'd5, 32'hFFFF_FFF8, 0, 1'b0);
        chk_reads("wrap", 1, 32'h0000_0000, 32'h0, 32'h0);
        chk_path("wrap", 2, 8'd1, 8'd2, 8'd0, 8'd0);
        chk("wrap_len", bif.path_length, 2);

        // Reset in the middle of a waiting read, then a clean restart.
        prep(8'd0, 8'd4, 8'd5, 32'h1000, 3, 1'b0);
        for (int i = 0; i < 50 && bif.mem_read_enable !== 1'b1; i++) @(negedge clock);
        chk("mid_fetch_reached", bif.mem_read_enable, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_mem_re", bif.mem_read_enable, 0);
        chk("mid_rst_pvalid", bif.path_valid, 0);
        chk("mid_rst_done", bif.done, 0);
        chk("mid_rst_error", bif.error, 0);
        chk("mid_rst_len", bif.path_length, 0);
        run(8'd0, 8'd4, 8'd5, 32'h1000, 0, 1'b0);
        chk_reads("restart", 3, 32'h1010, 32'h1008, 32'h1004);
        chk_path("restart", 4, 8'd0, 8'd1, 8'd2, 8'd4);
        chk("restart_len", bif.path_length, 4);
        chk("restart_err", bif.error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
